// File: rtl/vectored_intc.sv
// Vectored interrupt controller.
// Per-source level/edge trigger, priority arbitration with threshold and
// round-robin tie-break, claim/complete in-service tracking, level or pulse
// CPU interrupt pin with selectable polarity.
module vectored_intc #(
    parameter int N  = 16,
    parameter int P  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          int_in,
    input  logic [N-1:0]          int_enable,
    input  logic [N-1:0]          int_edge,
    input  logic [N-1:0][P-1:0]   int_priority,
    input  logic [N-1:0]          int_clear,
    input  logic [P-1:0]          threshold,
    input  logic                  claim_req,
    input  logic                  complete_req,
    input  logic [IW-1:0]         complete_id,
    input  logic                  out_mode,
    input  logic                  out_polarity,
    input  logic [W-1:0]          pulse_width,
    output logic [N-1:0]          int_status,
    output logic [N-1:0]          in_service,
    output logic                  claim_valid,
    output logic [IW-1:0]         claim_id,
    output logic                  complete_err,
    output logic                  int_out
);

    localparam logic [IW:0]   N_EXT   = N[IW:0];
    localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  in_service_q, in_service_d;
    logic [N-1:0]  prev_q, prev_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          raw_q, raw_d;
    logic          complete_err_q, complete_err_d;
    logic          claim_valid_q, claim_valid_d;
    logic          complete_ok_q, complete_ok_d;
    logic          out_mode_q, out_mode_d;

    logic [N-1:0]  rise;
    logic [N-1:0]  eligible;
    logic          found;
    logic [P-1:0]  best_prio;
    logic [IW-1:0] best_id;
    logic [IW:0]   scan_ext;
    logic [IW-1:0] scan_idx;
    logic          claim_fire;
    logic          complete_ok;
    logic [W-1:0]  pulse_len;
    logic          pulse_trig;

    // Per-source edge detect and eligibility (pending, not in service, above threshold)
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            assign rise[gi]     = int_in[gi] & ~prev_q[gi];
            assign eligible[gi] = pending_q[gi] & ~in_service_q[gi]
                                & (int_priority[gi] > threshold);
        end
    endgenerate

    // Arbitration: scan from rr_ptr with wrap; strict '>' keeps the first hit among equals
    always_comb begin
        found     = 1'b0;
        best_prio = '0;
        best_id   = '0;
        scan_ext  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_ext = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_ext >= N_EXT) begin
                scan_ext = scan_ext - N_EXT;
            end
            scan_idx = scan_ext[IW-1:0];
            if (eligible[scan_idx] && (!found || (int_priority[scan_idx] > best_prio))) begin
                found     = 1'b1;
                best_prio = int_priority[scan_idx];
                best_id   = scan_idx;
            end
        end
    end

    assign claim_valid = found;
    assign claim_id    = best_id;
    assign claim_fire  = claim_req & found;

    // Pending update, claim/complete handshake and round-robin pointer
    always_comb begin
        prev_d        = int_in;
        complete_ok   = complete_req
                      & ({1'b0, complete_id} < N_EXT)
                      & in_service_q[complete_id];
        complete_ok_d = complete_ok;
        for (int i = 0; i < N; i++) begin
            if (int_edge[i]) begin
                // A new rising edge wins over a clear or claim in the same cycle
                pending_d[i] = (rise[i] & int_enable[i])
                             | (pending_q[i] & ~int_clear[i]
                                & ~(claim_fire && (best_id == IW'(i))));
            end else begin
                pending_d[i] = int_in[i] & int_enable[i];
            end
        end
        // Complete is judged on pre-edge state, so claim+complete of one id errors
        in_service_d = in_service_q;
        if (complete_ok) begin
            in_service_d[complete_id] = 1'b0;
        end
        if (claim_fire) begin
            in_service_d[best_id] = 1'b1;
        end
        complete_err_d = complete_req & ~complete_ok;
        rr_ptr_d       = rr_ptr_q;
        if (claim_fire) begin
            rr_ptr_d = (best_id == LAST_ID) ? '0 : best_id + IW'(1);
        end
    end

    // Output pin generation: level follows claim_valid, pulse counts down a loaded length
    always_comb begin
        claim_valid_d = found;
        out_mode_d    = out_mode;
        pulse_len     = (pulse_width == '0) ? W'(1) : pulse_width;
        pulse_trig    = found & (~claim_valid_q | complete_ok_q);
        cnt_d         = cnt_q;
        raw_d         = raw_q;
        if (out_mode != out_mode_q) begin
            cnt_d = '0;
            raw_d = 1'b0;
        end else if (!out_mode) begin
            cnt_d = '0;
            raw_d = found;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
            raw_d = (cnt_d != '0);
        end else if (pulse_trig) begin
            cnt_d = pulse_len;
            raw_d = 1'b1;
        end else begin
            raw_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q      <= '0;
            in_service_q   <= '0;
            prev_q         <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            raw_q          <= 1'b0;
            complete_err_q <= 1'b0;
            claim_valid_q  <= 1'b0;
            complete_ok_q  <= 1'b0;
            out_mode_q     <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            in_service_q   <= in_service_d;
            prev_q         <= prev_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            raw_q          <= raw_d;
            complete_err_q <= complete_err_d;
            claim_valid_q  <= claim_valid_d;
            complete_ok_q  <= complete_ok_d;
            out_mode_q     <= out_mode_d;
        end
    end

    assign int_status   = pending_q;
    assign in_service   = in_service_q;
    assign complete_err = complete_err_q;
    assign int_out      = out_polarity ? raw_q : ~raw_q;

endmodule

// File: tb/tb_vectored_intc.sv
// Testbench for vectored_intc: directed steps from the test plan, then a
// randomized phase, all checked against a behavioural model of the rules.
module tb_vectored_intc;

    localparam int N  = 16;
    localparam int P  = 4;
    localparam int W  = 8;
    localparam int IW = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        int_in, int_enable, int_edge, int_clear;
    logic [N-1:0][P-1:0] int_priority;
    logic [P-1:0]        threshold;
    logic                claim_req, complete_req;
    logic [IW-1:0]       complete_id;
    logic                out_mode, out_polarity;
    logic [W-1:0]        pulse_width;
    logic [N-1:0]        int_status, in_service;
    logic                claim_valid, complete_err, int_out;
    logic [IW-1:0]       claim_id;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit [N-1:0] m_pend, m_ins, m_prev;
    int         m_rr, m_left;
    bit         m_raw, m_err, m_cv_prev, m_cok_prev, m_mode_prev;

    vectored_intc #(.N(N), .P(P), .W(W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .int_in(int_in), .int_enable(int_enable),
        .int_edge(int_edge), .int_priority(int_priority), .int_clear(int_clear),
        .threshold(threshold), .claim_req(claim_req), .complete_req(complete_req),
        .complete_id(complete_id), .out_mode(out_mode), .out_polarity(out_polarity),
        .pulse_width(pulse_width), .int_status(int_status), .in_service(in_service),
        .claim_valid(claim_valid), .claim_id(claim_id), .complete_err(complete_err),
        .int_out(int_out)
    );

    always #5 clk = ~clk;

    // Highest priority above threshold wins; equals go to the first one met scanning from rr
    function automatic void m_arb(output bit v, output int id);
        int best;
        int i;
        v = 1'b0; id = 0; best = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (m_pend[i] && !m_ins[i] && (int_priority[i] > threshold)
                && (int'(int_priority[i]) > best)) begin
                best = int'(int_priority[i]);
                id   = i;
                v    = 1'b1;
            end
        end
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic m_edge();
        bit v, cok, fire;
        int id;
        bit [N-1:0] np, ni;
        m_arb(v, id);
        if (!rst_n) begin
            m_pend = '0; m_ins = '0; m_prev = '0; m_rr = 0; m_left = 0;
            m_raw = 0; m_err = 0; m_cv_prev = 0; m_cok_prev = 0; m_mode_prev = 0;
        end else begin
            cok  = complete_req && m_ins[complete_id];
            fire = claim_req && v;
            np   = m_pend;
            for (int i = 0; i < N; i++) begin
                if (int_edge[i]) begin
                    if (int_in[i] && !m_prev[i] && int_enable[i]) np[i] = 1'b1;
                    else if (int_clear[i] || (fire && id == i)) np[i] = 1'b0;
                end else begin
                    np[i] = int_in[i] & int_enable[i];
                end
            end
            ni = m_ins;
            if (cok) ni[complete_id] = 1'b0;
            if (fire) ni[id] = 1'b1;
            m_err = complete_req && !cok;
            if (fire) m_rr = (id + 1) % N;
            if (out_mode != m_mode_prev) begin
                m_raw = 0; m_left = 0;
            end else if (!out_mode) begin
                m_raw = v; m_left = 0;
            end else if (m_raw) begin
                if (m_left > 0) m_left--;
                else m_raw = 0;
            end else if (v && (!m_cv_prev || m_cok_prev)) begin
                m_raw  = 1;
                m_left = (pulse_width == 0) ? 0 : int'(pulse_width) - 1;
            end
            m_cv_prev = v; m_cok_prev = cok; m_mode_prev = out_mode;
            m_pend = np; m_ins = ni; m_prev = int_in;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        bit v;
        int id;
        m_arb(v, id);
        chk({tag, ".status"}, 64'(int_status), 64'(m_pend));
        chk({tag, ".in_service"}, 64'(in_service), 64'(m_ins));
        chk({tag, ".claim_valid"}, 64'(claim_valid), 64'(v));
        if (v) chk({tag, ".claim_id"}, 64'(claim_id), 64'(id));
        chk({tag, ".complete_err"}, 64'(complete_err), 64'(m_err));
        chk({tag, ".int_out"}, 64'(int_out), 64'(out_polarity ? m_raw : !m_raw));
    endtask

    initial begin
        int lows;
        int exp_ids [4];
        exp_ids = '{1, 4, 9, 1};
        rst_n = 0; int_in = '0; int_enable = '1; int_edge = '0; int_clear = '0;
        int_priority = '0; threshold = '0; claim_req = 0; complete_req = 0;
        complete_id = '0; out_mode = 0; out_polarity = 1; pulse_width = '0;

        // Reset state
        tick(); tick();
        check_all("reset");
        chk("reset.int_out", 64'(int_out), 64'(1'b0));
        rst_n = 1;

        // Level source 3, priority 5
        int_priority[3] = 4'd5; int_in[3] = 1'b1;
        tick(); check_all("lvl.e0");
        chk("lvl.cv", 64'(claim_valid), 64'(1));
        chk("lvl.id", 64'(claim_id), 64'(3));
        tick(); check_all("lvl.e1");
        chk("lvl.out", 64'(int_out), 64'(1));
        claim_req = 1; tick(); claim_req = 0; check_all("lvl.claim");
        chk("lvl.ins3", 64'(in_service[3]), 64'(1));
        chk("lvl.cv0", 64'(claim_valid), 64'(0));
        complete_req = 1; complete_id = 4'd3; tick(); complete_req = 0; check_all("lvl.cmpl");
        chk("lvl.reelig", 64'(claim_valid), 64'(1));
        int_in[3] = 1'b0; tick(); check_all("lvl.drop"); tick(); check_all("lvl.idle");

        // Edge source 7, priority 2
        int_edge[7] = 1'b1; int_priority[7] = 4'd2;
        int_in[7] = 1'b1; tick(); int_in[7] = 1'b0; tick(); check_all("edge.set");
        chk("edge.pend", 64'(int_status[7]), 64'(1));
        int_clear[7] = 1'b1; tick(); int_clear[7] = 1'b0; check_all("edge.clr");
        chk("edge.cleared", 64'(int_status[7]), 64'(0));
        int_in[7] = 1'b1; int_clear[7] = 1'b1; tick(); check_all("edge.coinc");
        chk("edge.setwins", 64'(int_status[7]), 64'(1));
        int_in[7] = 1'b0; tick(); int_clear[7] = 1'b0; check_all("edge.clr2");

        // Round-robin among 1, 4, 9 at priority 6
        rst_n = 0; tick(); rst_n = 1;
        int_priority[1] = 4'd6; int_priority[4] = 4'd6; int_priority[9] = 4'd6;
        int_in = 16'h0212;
        tick(); check_all("rr.start");
        for (int r = 0; r < 4; r++) begin
            chk("rr.id", 64'(claim_id), 64'(exp_ids[r]));
            claim_req = 1; tick(); claim_req = 0; check_all("rr.claim");
            complete_req = 1; complete_id = IW'(exp_ids[r]); tick(); complete_req = 0;
            check_all("rr.cmpl");
        end
        int_in = '0; tick(); check_all("rr.end");

        // Threshold
        int_priority[2] = 4'd3; threshold = 4'd3; int_in[2] = 1'b1;
        tick(); tick(); check_all("thr.block");
        chk("thr.cv0", 64'(claim_valid), 64'(0));
        threshold = 4'd2; #1; check_all("thr.open");
        chk("thr.cv1", 64'(claim_valid), 64'(1));
        int_in = '0; threshold = '0; tick(); tick(); tick(); check_all("thr.idle");

        // Pulse mode, active-low, width 4 then width 0
        out_mode = 1; out_polarity = 0; pulse_width = 8'd4;
        tick(); tick(); check_all("pls.idle");
        int_in[7] = 1'b1; tick(); int_in[7] = 1'b0; check_all("pls.trig");
        lows = 0;
        for (int c = 0; c < 8; c++) begin
            tick(); check_all("pls.w4");
            if (int_out == 1'b0) lows++;
        end
        chk("pls.len4", 64'(lows), 64'(4));
        claim_req = 1; tick(); claim_req = 0; check_all("pls.claim");
        complete_req = 1; complete_id = 4'd7; tick(); complete_req = 0; check_all("pls.cmpl");
        pulse_width = 8'd0;
        int_in[7] = 1'b1; tick(); int_in[7] = 1'b0;
        lows = 0;
        for (int c = 0; c < 4; c++) begin
            tick(); check_all("pls.w0");
            if (int_out == 1'b0) lows++;
        end
        chk("pls.len1", 64'(lows), 64'(1));

        // Complete error and reset mid-pulse
        complete_req = 1; complete_id = 4'd5; tick(); complete_req = 0; check_all("err.set");
        chk("err.flag", 64'(complete_err), 64'(1));
        chk("err.ins", 64'(in_service), 64'(0));
        tick(); check_all("err.gone");
        chk("err.flag0", 64'(complete_err), 64'(0));
        int_clear[7] = 1'b1; tick(); int_clear[7] = 1'b0; check_all("rst.prep");
        pulse_width = 8'd10;
        int_in[7] = 1'b1; tick(); int_in[7] = 1'b0; tick(); tick(); check_all("rst.mid");
        chk("rst.active", 64'(int_out), 64'(0));
        rst_n = 0; tick(); check_all("rst.hit");
        chk("rst.out", 64'(int_out), 64'(1));
        chk("rst.status", 64'(int_status), 64'(0));
        chk("rst.ins", 64'(in_service), 64'(0));
        rst_n = 1; tick(); check_all("rst.after");

        // Randomized phase
        int_edge = 16'($urandom);
        for (int i = 0; i < N; i++) int_priority[i] = 4'($urandom);
        out_polarity = 1'($urandom);
        for (int c = 0; c < 400; c++) begin
            int_in       = 16'($urandom) & 16'($urandom);
            int_enable   = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
            int_clear    = 16'($urandom) & 16'($urandom) & 16'($urandom);
            claim_req    = 1'($urandom);
            complete_req = ($urandom % 3) == 0;
            complete_id  = 4'($urandom);
            if ($urandom % 2) begin
                for (int i = 0; i < N; i++) if (m_ins[i]) complete_id = IW'(i);
            end
            if ($urandom % 20 == 0) threshold = 4'($urandom_range(0, 6));
            if ($urandom % 30 == 0) out_mode = ~out_mode;
            if ($urandom % 20 == 0) pulse_width = 8'($urandom_range(0, 5));
            rst_n = ($urandom % 100) != 0;
            tick();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vectored_intc.md
# vectored_intc

Next-generation parametrised interrupt controller for the SoC interrupt path. It accepts N synchronous sources, each with its own trigger mode: level, or rising-edge latched. It arbitrates the pending sources by priority, using a priority threshold and round-robin tie-breaking. It drives one CPU interrupt pin in level or pulse mode, and tracks per-source in-service state through a claim/complete handshake so a handled source cannot re-interrupt until software completes it.

## Interface
- N, 16, number of sources (2..64); IW = $clog2(N)
- P, 4, priority width; priority 0 = source never eligible
- W, 8, pulse width counter width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- int_in  in  N  interrupt sources, already synchronous to clk
- int_enable  in  N  per-source enable
- int_edge  in  N  per-source trigger: 1 = rising edge, 0 = level-high
- int_priority  in  N x P  per-source priority
- int_clear  in  N  software clear of pending (edge sources)
- threshold  in  P  only priorities strictly greater than threshold are eligible
- claim_req  in  1  claim strobe
- complete_req  in  1  complete strobe
- complete_id  in  IW  source being completed
- out_mode  in  1  0 = level, 1 = pulse
- out_polarity  in  1  1 = active-high, 0 = active-low
- pulse_width  in  W  pulse length in cycles; 0 treated as 1
- int_status  out  N  pending bits
- in_service  out  N  in-service bits
- claim_valid  out  1  an eligible source exists
- claim_id  out  IW  current winner, valid when claim_valid
- complete_err  out  1  one-cycle flag: complete_id was not in service
- int_out  out  1  interrupt pin

## Operation
- Reset (rst_n low at a clock edge) clears the following, overriding all other activity that cycle: pending, in_service, the edge-history register, the round-robin pointer, the pulse counter and complete_err. The raw output is also cleared, so int_out equals ~out_polarity.
- Edge detect: prev[i] holds int_in[i] from the last cycle. rise[i] = int_in[i] & ~prev[i].
- Edge source pending: set on rise & enable. Cleared on a claim of i or on int_clear[i]. A set in the same cycle as a clear wins.
- Level source pending is the registered value of int_in & enable. int_clear has no effect on level sources.
- Eligible[i] = pending & ~in_service & (priority > threshold).
- Arbitration is combinational from registers. The winner is the eligible source with the highest priority.
  - Ties go to the first index at or after rr_ptr, scanning upward with wrap from N-1 to 0.
  - claim_valid = |eligible.
- Claim: on claim_req & claim_valid at an edge, in_service[claim_id] is set and pending is cleared if the source is edge-triggered. rr_ptr becomes claim_id+1 mod N.
  - claim_req with claim_valid = 0 is ignored.
- Complete: on complete_req, if in_service[complete_id] = 1 it is cleared next cycle.
  - Otherwise nothing changes and complete_err pulses high for one cycle.
  - complete_id >= N is treated as an error.
- Same-cycle claim and complete of the same id: the complete is evaluated against pre-edge state, so it errors, and the claim takes effect.
- Level output mode: raw_q <= claim_valid.
- Pulse output mode:
  - Trigger when claim_valid = 1 and claim_valid_q = 0 (a 0->1 rise), or on the cycle after a valid complete while claim_valid = 1.
  - Load cnt = max(pulse_width,1). raw_q stays 1 while cnt != 0; cnt decrements each cycle.
  - A trigger during an active pulse is ignored.
- int_out = out_polarity ? raw_q : ~raw_q.
- A change of out_mode mid-pulse aborts the pulse: cnt and raw_q are cleared in the cycle of the change.

## Timing
- Source assertion sampled at edge E0: pending visible after E0, claim_valid the same cycle, int_out asserted after E1. Total latency is 2 cycles.
- Edge sources need int_in low for at least 1 cycle between edges. A steady high produces one event only.
- Claim effects (pending clear, in_service set) are visible the cycle after the strobe. claim_id must be sampled in the strobe cycle.
- Complete clears in_service after 1 edge; the source can be eligible again in the next cycle.
- The pulse is high for exactly max(pulse_width,1) cycles, starting the cycle after the trigger.
- Reset asserted mid-pulse or mid-service: all state is cleared at that edge, with no partial pulse afterward.

## Test plan
- Level, N=16: src 3 at priority 5 high, threshold 0 -> claim_valid and claim_id=3 after 1 edge, int_out=1 after 2. Claim -> in_service[3]=1, claim_valid=0. Complete 3 while src still high -> re-eligible one cycle later.
- Edge: src 7 rises for 1 cycle at priority 2 -> pending stays set. int_clear[7] -> pending cleared. A rise coincident with the clear -> pending remains 1.
- Round-robin: srcs 1, 4, 9 all at priority 6, pending repeatedly -> claim_ids come out 1, 4, 9, 1 across successive claim/complete pairs.
- Threshold: src 2 at priority 3, threshold 3 -> claim_valid=0. Threshold set to 2 -> claim_valid=1 the same cycle.
- Pulse mode, polarity 0, pulse_width=4: src rises -> int_out low for exactly 4 cycles, then high. pulse_width=0 -> 1-cycle pulse.
- Complete of id 5 that is not in service -> complete_err=1 for one cycle, in_service unchanged. rst_n low mid-pulse -> int_out=~out_polarity and all status bits 0 at the next edge.
